// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encoding, parameter
// defaults and the state-to-LED decode.
package stopwatch_pkg;

  localparam int TIME_W_DEF    = 24;
  localparam int LAP_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAP  = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  // LED word is {STOP, LAP, RUN}; IDLE shows all dark.
  function automatic logic [2:0] led_of(input state_e st);
    logic [2:0] led;
    case (st)
      ST_RUN:  led = 3'b001;
      ST_LAP:  led = 3'b010;
      ST_STOP: led = 3'b100;
      default: led = 3'b000;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/stopwatch_lap_buf.sv
// Circular lap store: write pointer wraps mod LAP_DEPTH, saturating count and
// sticky overwrite flag; combinational read by physical index.
module stopwatch_lap_buf #(
  parameter int TIME_W    = 24,
  parameter int LAP_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [TIME_W-1:0]               wr_data,
  input  logic                            clr,
  input  logic [$clog2(LAP_DEPTH)-1:0]    rd_idx,
  output logic [TIME_W-1:0]               rd_data,
  output logic [$clog2(LAP_DEPTH+1)-1:0]  cnt,
  output logic                            ovf,
  output logic [$clog2(LAP_DEPTH)-1:0]    oldest
);

  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = $clog2(LAP_DEPTH + 1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(LAP_DEPTH);

  logic [TIME_W-1:0] mem_r [LAP_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [CW-1:0]     cnt_r;
  logic              ovf_r;
  logic              full_s;

  assign full_s  = (cnt_r == DEPTH_C);
  // Once full, the next write lands on the oldest entry, i.e. the write pointer.
  assign oldest  = full_s ? wr_ptr_r : {AW{1'b0}};
  assign rd_data = mem_r[rd_idx];
  assign cnt     = cnt_r;
  assign ovf     = ovf_r;

  // Entry storage, write pointer, lap count and overwrite flag.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < LAP_DEPTH; i++) begin
        mem_r[i] <= {TIME_W{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      ovf_r    <= 1'b0;
    end else if (wr_en) begin
      mem_r[wr_ptr_r] <= wr_data;
      wr_ptr_r        <= wr_ptr_r + ONE_A;
      if (full_s) begin
        ovf_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + ONE_C;
      end
    end else begin
      wr_ptr_r <= wr_ptr_r;
      cnt_r    <= cnt_r;
      ovf_r    <= ovf_r;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM (IDLE/RUN/LAP/STOP) driving timer enable/clear, display
// mux and LEDs. Define LAP_RECALL_EN to build lap recall in STOP.
import stopwatch_pkg::*;

module stopwatch_ctrl #(
  parameter int TIME_W    = TIME_W_DEF,
  parameter int LAP_DEPTH = LAP_DEPTH_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start_stop,
  input  logic              i_lap_clr,
  input  logic              i_recall,
  input  logic [TIME_W-1:0] i_time,
  output logic              o_run,
  output logic              o_clr,
  output logic [TIME_W-1:0] o_disp,
  output logic [2:0]        o_led,
  output logic [3:0]        o_lap_cnt,
  output logic              o_lap_ovf
);

  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = $clog2(LAP_DEPTH + 1);

  state_e            state_r;
  state_e            state_nxt_s;
  logic              lap_wr_s;
  logic              lap_clr_s;
  logic [TIME_W-1:0] freeze_r;
  logic [TIME_W-1:0] rd_data_s;
  logic [AW-1:0]     rd_idx_s;
  logic [AW-1:0]     oldest_s;
  logic [CW-1:0]     lap_cnt_s;
  logic [4:0]        cnt_ext_s;
  logic              recall_show_s;

  stopwatch_lap_buf #(
    .TIME_W    (TIME_W),
    .LAP_DEPTH (LAP_DEPTH)
  ) u_lap_buf (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .wr_en   (lap_wr_s),
    .wr_data (i_time),
    .clr     (lap_clr_s),
    .rd_idx  (rd_idx_s),
    .rd_data (rd_data_s),
    .cnt     (lap_cnt_s),
    .ovf     (o_lap_ovf),
    .oldest  (oldest_s)
  );

  // A 16-deep buffer cannot report 16 in four bits, so the count pins at 15.
  assign cnt_ext_s = 5'(lap_cnt_s);
  assign o_lap_cnt = cnt_ext_s[4] ? 4'hF : cnt_ext_s[3:0];

  // Next-state decode; start/stop always takes priority over lap/clear.
  always_comb begin
    state_nxt_s = state_r;
    lap_wr_s    = 1'b0;
    lap_clr_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_start_stop) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_start_stop) begin
          state_nxt_s = ST_STOP;
        end else if (i_lap_clr) begin
          state_nxt_s = ST_LAP;
          lap_wr_s    = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_LAP: begin
        if (i_start_stop) begin
          state_nxt_s = ST_STOP;
        end else if (i_lap_clr) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_LAP;
        end
      end
      ST_STOP: begin
        if (i_start_stop) begin
          state_nxt_s = ST_RUN;
        end else if (i_lap_clr) begin
          state_nxt_s = ST_IDLE;
          lap_clr_s   = 1'b1;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

`ifdef LAP_RECALL_EN
  logic          recall_act_r;
  logic [AW-1:0] recall_idx_r;
  logic [AW-1:0] recall_idx_nxt_s;
  logic          recall_go_s;

  // Recall index is logical (0 = oldest); it wraps after the newest stored lap.
  always_comb begin
    recall_go_s      = i_recall && (state_r == ST_STOP) && (state_nxt_s == ST_STOP) &&
                       (lap_cnt_s != {CW{1'b0}});
    recall_idx_nxt_s = recall_idx_r;
    if (recall_go_s) begin
      if (!recall_act_r) begin
        recall_idx_nxt_s = {AW{1'b0}};
      end else if ((CW'(recall_idx_r) + CW'(1)) == lap_cnt_s) begin
        recall_idx_nxt_s = {AW{1'b0}};
      end else begin
        recall_idx_nxt_s = recall_idx_r + AW'(1);
      end
    end else begin
      recall_idx_nxt_s = recall_idx_r;
    end
    recall_show_s = recall_go_s || (recall_act_r && (state_nxt_s == ST_STOP));
    rd_idx_s      = oldest_s + recall_idx_nxt_s;
  end

  // Recall session state; any exit from STOP ends the session.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      recall_act_r <= 1'b0;
      recall_idx_r <= {AW{1'b0}};
    end else if (state_nxt_s != ST_STOP) begin
      recall_act_r <= 1'b0;
      recall_idx_r <= {AW{1'b0}};
    end else begin
      recall_act_r <= recall_act_r | recall_go_s;
      recall_idx_r <= recall_idx_nxt_s;
    end
  end
`else
  logic unused_recall_s;

  assign rd_idx_s        = {AW{1'b0}};
  assign recall_show_s   = 1'b0;
  assign unused_recall_s = ^{i_recall, rd_data_s, oldest_s};
`endif

  // FSM state and registered outputs, all decoded from the next state.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_r  <= ST_IDLE;
      o_run    <= 1'b0;
      o_clr    <= 1'b0;
      o_led    <= 3'b000;
      o_disp   <= {TIME_W{1'b0}};
      freeze_r <= {TIME_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      o_run   <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_LAP);
      o_clr   <= lap_clr_s;
      o_led   <= led_of(state_nxt_s);
      if (lap_wr_s) begin
        freeze_r <= i_time;
      end else begin
        freeze_r <= freeze_r;
      end
      if (state_nxt_s == ST_LAP) begin
        o_disp <= lap_wr_s ? i_time : freeze_r;
      end else if (recall_show_s) begin
        o_disp <= rd_data_s;
      end else begin
        o_disp <= i_time;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with hand-computed expectations; recall
// checks are compiled when LAP_RECALL_EN is defined.
module tb_stopwatch_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start_stop = 1'b0;
  logic        i_lap_clr = 1'b0;
  logic        i_recall = 1'b0;
  logic [23:0] i_time = 24'h0;
  logic        o_run;
  logic        o_clr;
  logic [23:0] o_disp;
  logic [2:0]  o_led;
  logic [3:0]  o_lap_cnt;
  logic        o_lap_ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  stopwatch_ctrl dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start_stop (i_start_stop),
    .i_lap_clr    (i_lap_clr),
    .i_recall     (i_recall),
    .i_time       (i_time),
    .o_run        (o_run),
    .o_clr        (o_clr),
    .o_disp       (o_disp),
    .o_led        (o_led),
    .o_lap_cnt    (o_lap_cnt),
    .o_lap_ovf    (o_lap_ovf)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_ss();
    i_start_stop = 1'b1;
    tick();
    i_start_stop = 1'b0;
  endtask

  task automatic pulse_lc();
    i_lap_clr = 1'b1;
    tick();
    i_lap_clr = 1'b0;
  endtask

  task automatic pulse_rc();
    i_recall = 1'b1;
    tick();
    i_recall = 1'b0;
  endtask

  // Capture a lap at value v, then release the freeze.
  task automatic do_lap(input logic [23:0] v);
    i_time = v;
    pulse_lc();
    pulse_lc();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_run"}, 32'(o_run), 32'd0);
    chk({tag, "_clr"}, 32'(o_clr), 32'd0);
    chk({tag, "_disp"}, 32'(o_disp), 32'd0);
    chk({tag, "_led"}, 32'(o_led), 32'd0);
    chk({tag, "_cnt"}, 32'(o_lap_cnt), 32'd0);
    chk({tag, "_ovf"}, 32'(o_lap_ovf), 32'd0);
  endtask

  initial begin
    // Reset dominates a start/stop pulse.
    i_start_stop = 1'b1;
    i_time = 24'h000042;
    tick();
    tick();
    chk_reset("rst");
    i_start_stop = 1'b0;
    i_rst = 1'b1;
    i_time = 24'h000055;
    tick();
    chk("idle_disp", 32'(o_disp), 32'h55);

    // IDLE ignores lap/clear.
    pulse_lc();
    chk("idle_lc_led", 32'(o_led), 32'h0);
    chk("idle_lc_cnt", 32'(o_lap_cnt), 32'h0);

    // Start.
    i_time = 24'h000100;
    pulse_ss();
    chk("start_run", 32'(o_run), 32'h1);
    chk("start_led", 32'(o_led), 32'h1);
    chk("start_disp", 32'(o_disp), 32'h100);
    i_time = 24'h000101;
    tick();
    chk("run_track", 32'(o_disp), 32'h101);

    // Lap freeze and release.
    i_time = 24'h000123;
    pulse_lc();
    chk("lap_disp", 32'(o_disp), 32'h123);
    chk("lap_led", 32'(o_led), 32'h2);
    chk("lap_run", 32'(o_run), 32'h1);
    chk("lap_cnt", 32'(o_lap_cnt), 32'h1);
    i_time = 24'h000200;
    tick();
    chk("lap_hold", 32'(o_disp), 32'h123);
    i_time = 24'h000201;
    pulse_lc();
    chk("rel_disp", 32'(o_disp), 32'h201);
    chk("rel_led", 32'(o_led), 32'h1);

    // Simultaneous start/stop and lap: stop wins, no lap captured.
    i_start_stop = 1'b1;
    i_lap_clr = 1'b1;
    tick();
    i_start_stop = 1'b0;
    i_lap_clr = 1'b0;
    chk("both_led", 32'(o_led), 32'h4);
    chk("both_run", 32'(o_run), 32'h0);
    chk("both_cnt", 32'(o_lap_cnt), 32'h1);

    // Resume without clear.
    pulse_ss();
    chk("resume_led", 32'(o_led), 32'h1);
    chk("resume_cnt", 32'(o_lap_cnt), 32'h1);
    chk("resume_clr", 32'(o_clr), 32'h0);

    // Laps 2..4 fill the buffer, lap 5 overwrites lap 1.
    do_lap(24'h000002);
    do_lap(24'h000003);
    do_lap(24'h000004);
    chk("full_cnt", 32'(o_lap_cnt), 32'h4);
    chk("full_ovf", 32'(o_lap_ovf), 32'h0);
    i_time = 24'h000005;
    pulse_lc();
    chk("ovf_cnt", 32'(o_lap_cnt), 32'h4);
    chk("ovf_flag", 32'(o_lap_ovf), 32'h1);
    chk("ovf_disp", 32'(o_disp), 32'h5);

    // LAP -> STOP.
    i_time = 24'h000300;
    pulse_ss();
    chk("lapstop_led", 32'(o_led), 32'h4);
    chk("lapstop_run", 32'(o_run), 32'h0);
    chk("lapstop_disp", 32'(o_disp), 32'h300);

`ifdef LAP_RECALL_EN
    // Oldest surviving lap is lap 2; lap 1 was overwritten by lap 5.
    pulse_rc();
    chk("ovf_rc0", 32'(o_disp), 32'h2);
    pulse_rc();
    pulse_rc();
    pulse_rc();
    chk("ovf_rc3", 32'(o_disp), 32'h5);
    pulse_rc();
    chk("ovf_rc4", 32'(o_disp), 32'h2);
`else
    i_time = 24'h000077;
    pulse_rc();
    chk("rc_ignored", 32'(o_disp), 32'h77);
`endif

    // STOP -> IDLE clears laps and pulses o_clr once.
    pulse_lc();
    chk("clr_pulse", 32'(o_clr), 32'h1);
    chk("clr_cnt", 32'(o_lap_cnt), 32'h0);
    chk("clr_ovf", 32'(o_lap_ovf), 32'h0);
    chk("clr_led", 32'(o_led), 32'h0);
    tick();
    chk("clr_once", 32'(o_clr), 32'h0);

    // Recall with no laps is ignored.
    pulse_ss();
    pulse_ss();
    i_time = 24'h000088;
    pulse_rc();
    chk("rc_empty", 32'(o_disp), 32'h88);

    // Three laps then recall sequence, reset mid-sequence.
    pulse_ss();
    do_lap(24'h000010);
    do_lap(24'h000020);
    do_lap(24'h000030);
    chk("three_cnt", 32'(o_lap_cnt), 32'h3);
    pulse_ss();
    i_time = 24'h000999;
`ifdef LAP_RECALL_EN
    pulse_rc();
    chk("rc1", 32'(o_disp), 32'h10);
    pulse_rc();
    chk("rc2", 32'(o_disp), 32'h20);
    tick();
    chk("rc_hold", 32'(o_disp), 32'h20);
    pulse_rc();
    chk("rc3", 32'(o_disp), 32'h30);
    pulse_rc();
    chk("rc4", 32'(o_disp), 32'h10);
`else
    pulse_rc();
    chk("rc_off", 32'(o_disp), 32'h999);
`endif
    i_rst = 1'b0;
    i_recall = 1'b1;
    tick();
    i_recall = 1'b0;
    chk_reset("midrst");
    i_rst = 1'b1;
    i_time = 24'h000abc;
    tick();
    chk("post_rst_disp", 32'(o_disp), 32'habc);
    chk("post_rst_led", 32'(o_led), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TIME_W, default 24, width of the time word from the timer.
REQ-002 SHALL have parameter LAP_DEPTH, default 4, number of lap entries (power of two, 2..16).
REQ-003 SHALL have port i_clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port i_start_stop  input  1  debounced one-cycle start/stop pulse.
REQ-006 SHALL have port i_lap_clr  input  1  debounced one-cycle lap/clear pulse.
REQ-007 SHALL have port i_recall  input  1  debounced one-cycle lap-recall pulse.
REQ-008 SHALL have port i_time  input  TIME_W  live time word from the timer.
REQ-009 SHALL have port o_run  output  1  count enable to the timer.
REQ-010 SHALL have port o_clr  output  1  one-cycle clear pulse to the timer.
REQ-011 SHALL have port o_disp  output  TIME_W  value forwarded to the display formatter.
REQ-012 SHALL have port o_led  output  3  state indicator {STOP,LAP,RUN}, one-hot; IDLE = 000.
REQ-013 SHALL have port o_lap_cnt  output  4  stored laps, saturating at LAP_DEPTH.
REQ-014 SHALL have port o_lap_ovf  output  1  sticky flag: a lap overwrote the oldest entry.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, LAP, STOP.
REQ-016 IDLE: i_start_stop -> RUN; i_lap_clr and i_recall ignored.
REQ-017 RUN: i_start_stop -> STOP; i_lap_clr -> LAP, capturing i_time into the freeze register and the lap buffer in that cycle.
REQ-018 LAP: i_lap_clr -> RUN, releasing the freeze; i_start_stop -> STOP.
REQ-019 STOP: i_start_stop -> RUN (resume, no clear); i_lap_clr -> IDLE, clearing the lap buffer, o_lap_cnt and o_lap_ovf.
REQ-020 Simultaneous i_start_stop and i_lap_clr: i_start_stop SHALL win; i_lap_clr is dropped.
REQ-021 o_run SHALL be 1 exactly when the state is RUN or LAP (registered, valid the cycle after the transition edge).
REQ-022 o_clr SHALL pulse high for exactly one cycle, the cycle after the STOP->IDLE transition.
REQ-023 o_disp SHALL be registered, 1-cycle latency: the freeze register in LAP; the recalled entry during recall; else i_time.
REQ-024 Lap buffer SHALL be circular: write pointer increments mod LAP_DEPTH; when full, overwrite oldest and set o_lap_ovf.
REQ-025 o_lap_cnt SHALL increment per captured lap and saturate at LAP_DEPTH.

Reset
REQ-026 i_rst low at any clock edge SHALL dominate all inputs, including mid-operation.
REQ-027 Reset SHALL force state IDLE, o_run=0, o_clr=0, o_disp=0, o_led=000, o_lap_cnt=0, o_lap_ovf=0, pointers=0, lap entries=0.

Configuration
REQ-028 With LAP_RECALL_EN defined: in STOP, each i_recall pulse SHALL display the next stored lap, oldest first, wrapping after the newest.
REQ-029 With LAP_RECALL_EN defined: recall SHALL end on leaving STOP; i_recall with o_lap_cnt=0 SHALL be ignored.
REQ-030 Without LAP_RECALL_EN: i_recall SHALL be present but ignored; recall pointer logic SHALL not be built.

Structure
REQ-031 Shared package stopwatch_pkg SHALL hold the state encoding, TIME_W default and LAP_DEPTH default.
REQ-032 Lap storage SHALL be sub-module stopwatch_lap_buf (write, clear, read-index ports); the FSM stays in stopwatch_ctrl.

Verification
REQ-033 Reset, then i_start_stop pulse -> o_run=1 and o_led=001 next cycle; o_disp tracks i_time with 1-cycle lag.
REQ-034 RUN, i_time=0x000123, i_lap_clr -> o_disp frozen at 0x000123, o_led=010, o_run=1, o_lap_cnt=1; second i_lap_clr -> o_disp live again.
REQ-035 RUN, 5 laps with LAP_DEPTH=4 -> o_lap_cnt=4, o_lap_ovf=1, lap 1 overwritten by lap 5.
REQ-036 STOP, i_lap_clr -> IDLE, o_clr high for exactly one cycle, o_lap_cnt=0, o_lap_ovf=0.
REQ-037 RUN, i_start_stop and i_lap_clr in the same cycle -> STOP, no lap captured.
REQ-038 LAP_RECALL_EN, laps 0x10, 0x20, 0x30 stored, STOP, 4 i_recall pulses -> o_disp 0x10, 0x20, 0x30, 0x10; i_rst low mid-sequence -> all reset values next cycle.
